// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the skid-buffered pipeline stage controller.
// State encoding doubles as the entry count.
package pipe_ctrl_pkg;

  localparam int DATA_W = 70;

  typedef logic [1:0] occ_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/wallOfDFFsL70.sv
// Enabled register wall with async active-high clear.
// Holds one pipeline payload.
import pipe_ctrl_pkg::*;

module wallOfDFFsL70 #(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_skid_ctrl.sv
// Two-entry skid stage: main wall feeds downstream, skid absorbs
// one payload under stall. All handshake outputs come from flops.
import pipe_ctrl_pkg::*;

module pipe_skid_ctrl #(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output occ_t             occupancy
);

  skid_state_t state, nxt;

  logic in_fire, out_fire;
  logic main_en, skid_en, sel_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    nxt      = state;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    sel_skid = 1'b0;
    if (flush) begin
      nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_en = 1'b1;
            nxt     = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            in_fire & out_fire: main_en = 1'b1;
            in_fire & ~out_fire: begin
              skid_en = 1'b1;
              nxt     = TWO;
            end
            ~in_fire & out_fire: nxt = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (out_fire) begin
            main_en  = 1'b1;
            sel_skid = 1'b1;
            nxt      = ONE;
          end
        end
        default: nxt = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from next-state, never from inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= '0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt != TWO);
      out_valid <= (nxt != EMPTY);
      occupancy <= occ_t'(nxt);
    end
  end

  assign main_d = sel_skid ? skid_q : in_data;

  wallOfDFFsL70 #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  wallOfDFFsL70 #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_ctrl.sv
// Bench for pipe_skid_ctrl: queue model of held payloads,
// directed scenarios plus randomized valid/ready/flush.
module tb_pipe_skid_ctrl;

  localparam int W = 70;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [1:0]   occupancy;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  bit mon = 1'b0;

  logic [W-1:0] q[$];

  pipe_skid_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of depth 2; ready means not full.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      automatic bit inf  = in_valid && (q.size() < 2);
      automatic bit outf = (q.size() > 0) && out_ready;
      if (outf) delivered++;
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (mon && !reset) begin
      chk("m_valid", W'(out_valid), W'(q.size() > 0));
      chk("m_ready", W'(in_ready), W'(q.size() < 2));
      chk("m_occ", W'(occupancy), W'(q.size()));
      if (q.size() > 0)
        chk("m_data", out_data, q[0]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(bit iv, logic [W-1:0] d, bit ordy, bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", W'(in_ready), W'(1));
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_occ", W'(occupancy), W'(0));
    chk("rst_data", out_data, '0);
    mon = 1'b1;

    // streaming
    drive(1, 70'h1, 1, 0);
    tick();
    chk("st_d1", out_data, 70'h1);
    chk("st_occ1", W'(occupancy), W'(1));
    drive(1, 70'h2, 1, 0);
    tick();
    chk("st_d2", out_data, 70'h2);
    drive(1, 70'h3, 1, 0);
    tick();
    chk("st_d3", out_data, 70'h3);
    chk("st_rdy", W'(in_ready), W'(1));
    chk("st_occ3", W'(occupancy), W'(1));
    drive(0, '0, 1, 0);
    tick();
    chk("st_empty", W'(out_valid), W'(0));

    // backpressure
    drive(1, 70'hA, 0, 0);
    tick();
    chk("bp_occ1", W'(occupancy), W'(1));
    chk("bp_dA", out_data, 70'hA);
    drive(1, 70'hB, 0, 0);
    tick();
    chk("bp_occ2", W'(occupancy), W'(2));
    chk("bp_rdy0", W'(in_ready), W'(0));
    drive(0, '0, 1, 0);
    tick();
    chk("bp_dB", out_data, 70'hB);
    chk("bp_rdy1", W'(in_ready), W'(1));
    chk("bp_occ_b", W'(occupancy), W'(1));
    tick();
    chk("bp_drain", W'(out_valid), W'(0));

    // flush while full
    drive(1, 70'hA, 0, 0);
    tick();
    drive(1, 70'hB, 0, 0);
    tick();
    chk("fl_occ2", W'(occupancy), W'(2));
    drive(1, 70'hC, 0, 1);
    tick();
    chk("fl_valid", W'(out_valid), W'(0));
    chk("fl_occ", W'(occupancy), W'(0));
    chk("fl_rdy", W'(in_ready), W'(1));
    drive(0, '0, 1, 0);
    tick();
    chk("fl_noC", W'(out_valid), W'(0));

    // async reset while full
    drive(1, 70'h11, 0, 0);
    tick();
    drive(1, 70'h22, 0, 0);
    tick();
    drive(0, '0, 0, 0);
    chk("ar_occ2", W'(occupancy), W'(2));
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", W'(out_valid), W'(0));
    chk("ar_occ", W'(occupancy), W'(0));
    chk("ar_rdy", W'(in_ready), W'(1));
    chk("ar_data", out_data, '0);
    #1 reset = 1'b0;
    tick();

    // randomized traffic
    for (int i = 0; i < 10000; i++) begin
      automatic logic sv_rdy;
      drive($urandom_range(0, 9) < 7,
            W'({$urandom(), $urandom(), $urandom()}),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 2);
      #1;
      sv_rdy = in_ready;
      out_ready = ~out_ready;
      in_valid  = ~in_valid;
      #1;
      chk("comb_rdy", W'(in_ready), W'(sv_rdy));
      out_ready = ~out_ready;
      in_valid  = ~in_valid;
      tick();
    end

    drive(0, '0, 1, 0);
    repeat (3) tick();
    chk("final_empty", W'(out_valid), W'(0));
    if (delivered < 1000) begin
      total++;
      bad++;
      $display("FAIL delivered got=%0d want>=1000", delivered);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_ctrl.md
# pipe_skid_ctrl

Two-entry skid-buffered pipeline stage controller for the out-of-order core's 70-bit inter-stage registers. It decides every cycle which of two enabled register walls (main, skid) captures incoming data, and drives valid/ready handshakes on both sides. It also handles a synchronous flush on branch mispredict or exception. It sits between any two pipeline stages (e.g. rename→dispatch) and replaces hand-wired stall logic with a uniform, fully registered ready path.

## Interface
- WIDTH, 70, payload width in bits
- clk  input  1  stage clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream has a payload
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  stage can accept; driven straight from a flop
- out_valid  output  1  main entry holds a payload
- out_data  output  WIDTH  main entry payload
- out_ready  input  1  downstream accepts
- occupancy  output  2  entries held, 0..2

## Operation
- Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (0 entries), ONE (main full), TWO (main + skid full). occupancy = 0/1/2 respectively.
- EMPTY: in_fire → main loads in_data, go ONE.
- ONE: in_fire & out_fire → main loads in_data, stay ONE. in_fire only → skid loads in_data, go TWO. out_fire only → go EMPTY. Neither → hold.
- TWO: in_ready is 0, so in_fire cannot occur. out_fire → main loads skid, go ONE. Otherwise hold.
- flush has top priority. Next state is EMPTY regardless of in_fire/out_fire that cycle. Any in_fire that cycle is dropped. An out_fire that cycle still counts as delivered downstream.
- in_ready = (state != TWO), registered from next-state. There is no combinational path from out_ready or in_valid to in_ready.
- out_valid = (state != EMPTY). out_data = main register.
- Wall enables are one-hot-or-zero per cycle for each wall. The main wall's mux selects in_data or the skid data.
- Payload is never reordered, duplicated or dropped except by flush.

## Timing
- Reset values: state EMPTY, in_ready 1, out_valid 0, occupancy 0, out_data all zeros, skid all zeros.
- Reset mid-operation clears both entries immediately (asynchronous). Held payloads are lost.
- Latency from in_fire to out_valid: 1 cycle.
- Throughput: 1 payload/cycle sustained when out_ready stays high.
- Downstream stall: one extra payload is absorbed in the skid. in_ready falls the cycle after the second capture.
- Stall release from TWO: the skid payload appears on out_data 1 cycle after out_fire. in_ready rises in the same cycle.
- flush asserted: the cycle after, out_valid=0, in_ready=1, occupancy=0.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (EMPTY, ONE, TWO)
  - the localparam for default payload width 70
  - the occupancy type
- One sub-module is natural: the payload storage is two instances of the team's enabled register wall wallOfDFFsL70 (main, skid). The controller drives only their enable, d and reset.
- Control FSM and mux logic live in pipe_skid_ctrl itself.

## Test plan
- Reset then idle: reset=1 for 2 cycles, then release → in_ready=1, out_valid=0, occupancy=0, out_data=0.
- Streaming: out_ready=1, in_valid=1 with payloads 0x1, 0x2, 0x3 on consecutive cycles → out_data is 0x1, 0x2, 0x3 one cycle later each. Occupancy stays 1 and in_ready stays 1.
- Backpressure: out_ready=0, send 0xA then 0xB → occupancy goes 1 then 2, in_ready=0. Raise out_ready → out_data 0xA, then 0xB. in_ready returns to 1 the cycle after the first out_fire.
- Flush in TWO: hold 0xA, 0xB, assert flush with in_valid=1 carrying 0xC → next cycle out_valid=0, occupancy=0. 0xC never appears.
- Async reset mid-stall: in TWO, assert reset between clock edges → out_valid and occupancy drop to 0 without a clock edge, in_ready=1.
- Random valid/ready for 10k cycles against a scoreboard queue → output order matches input order exactly. in_ready never depends combinationally on out_ready.
